multicycle_cu: RTL

Parametrised successor to the 4-register control unit of simple_cpu. It is a multi-cycle FSM controller with a generic register-file depth and data width, plus a valid/ready instruction intake. It drives the registered ALU and the data memory (reg_mem) through the existing sel1/sel3/w_r muxing scheme. It adds single-cycle store strobes, a retire pulse, a NOP type, and a debug register read port.

---
 rtl/multicycle_cu.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: valid/ready instruction intake, parametrised register file,
// and the sel1/sel3/w_r control that sequences a registered ALU and the data memory.
module multicycle_cu #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned REG_BITS    = 2,
  parameter int unsigned ADDR_BITS   = 5,
  parameter int unsigned INSTR_WIDTH = 2 + 3*REG_BITS + DATA_WIDTH + 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [DATA_WIDTH-1:0]  result2,
  output logic [DATA_WIDTH-1:0]  operand1,
  output logic [DATA_WIDTH-1:0]  operand2,
  output logic [DATA_WIDTH-1:0]  offset,
  output logic [3:0]             opcode,
  output logic                   sel1,
  output logic                   sel3,
  output logic                   w_r,
  output logic                   retired,
  output logic                   busy,
  input  logic [REG_BITS-1:0]    dbg_addr,
  output logic [DATA_WIDTH-1:0]  dbg_data
);

  localparam int unsigned NUM_REGS = 2**REG_BITS;
  localparam int unsigned OFF_LSB  = 4;
  localparam int unsigned RS2_LSB  = OFF_LSB + DATA_WIDTH;
  localparam int unsigned RS1_LSB  = RS2_LSB + REG_BITS;
  localparam int unsigned RD_LSB   = RS1_LSB + REG_BITS;
  localparam int unsigned TYPE_LSB = RD_LSB + REG_BITS;

  // Memory address width is carried for the surrounding datapath; only sanity-checked here.
  if (ADDR_BITS == 0 || INSTR_WIDTH != TYPE_LSB + 2) begin : g_param_check
    $error("multicycle_cu: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DECODE     = 3'd1,
    S_EXECUTE    = 3'd2,
    S_MEM_ACCESS = 3'd3,
    S_WRITE_BACK = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    T_NOP   = 2'b00,
    T_STD   = 2'b01,
    T_LOAD  = 2'b10,
    T_STORE = 2'b11
  } itype_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [INSTR_WIDTH-1:0]  r_instr;
  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]   r_operand1, r_operand2, r_offset;
  logic [3:0]              r_opcode;
  logic                    r_sel1, r_sel3, r_w_r, r_retired, r_busy, r_ready;

  logic                    w_retired_nxt, w_wr_nxt, w_load_ops, w_reg_we;
  itype_t                  w_type_in, w_type;
  logic [REG_BITS-1:0]     w_rd, w_rs1, w_rs2;

  assign w_type_in = itype_t'(instr[TYPE_LSB +: 2]);
  assign w_type    = itype_t'(r_instr[TYPE_LSB +: 2]);
  assign w_rd      = r_instr[RD_LSB  +: REG_BITS];
  assign w_rs1     = r_instr[RS1_LSB +: REG_BITS];
  assign w_rs2     = r_instr[RS2_LSB +: REG_BITS];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next state plus the strobes that are registered on entry to their cycle
  always_comb begin
    w_next        = r_state;
    w_retired_nxt = 1'b0;
    w_wr_nxt      = 1'b0;
    w_load_ops    = 1'b0;
    w_reg_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_next        = S_DECODE;
          w_retired_nxt = (w_type_in == T_NOP);
        end
      end
      S_DECODE: begin
        if (w_type == T_NOP) begin
          w_next = S_IDLE;
        end else begin
          w_next     = S_EXECUTE;
          w_load_ops = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (w_type == T_LOAD || w_type == T_STORE) begin
          w_next        = S_MEM_ACCESS;
          w_wr_nxt      = (w_type == T_STORE);
          w_retired_nxt = (w_type == T_STORE);
        end else begin
          w_next        = S_WRITE_BACK;
          w_retired_nxt = 1'b1;
        end
      end
      S_MEM_ACCESS: begin
        if (w_type == T_LOAD) begin
          w_next        = S_WRITE_BACK;
          w_retired_nxt = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WRITE_BACK: begin
        w_reg_we = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers: instruction latch, operand drive, register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr    <= '0;
      r_operand1 <= '0;
      r_operand2 <= '0;
      r_offset   <= '0;
      r_opcode   <= 4'hF;
      r_sel1     <= 1'b0;
      r_sel3     <= 1'b0;
      r_w_r      <= 1'b0;
      r_retired  <= 1'b0;
      r_busy     <= 1'b0;
      r_ready    <= 1'b1;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= DATA_WIDTH'(i);
    end else begin
      r_w_r     <= w_wr_nxt;
      r_retired <= w_retired_nxt;
      r_busy    <= (w_next != S_IDLE);
      r_ready   <= (w_next == S_IDLE);
      if (r_state == S_IDLE && instr_valid) r_instr <= instr;
      if (w_load_ops) begin
        r_operand1 <= r_regs[w_rs1];
        r_operand2 <= (w_type == T_STD) ? r_regs[w_rs2] : r_regs[w_rd];
        r_offset   <= r_instr[OFF_LSB +: DATA_WIDTH];
        r_opcode   <= r_instr[3:0];
        r_sel1     <= (w_type == T_STD);
        r_sel3     <= (w_type != T_STD);
      end
      if (w_reg_we) r_regs[w_rd] <= result2;
    end
  end

  assign instr_ready = r_ready;
  assign operand1    = r_operand1;
  assign operand2    = r_operand2;
  assign offset      = r_offset;
  assign opcode      = r_opcode;
  assign sel1        = r_sel1;
  assign sel3        = r_sel3;
  assign w_r         = r_w_r;
  assign retired     = r_retired;
  assign busy        = r_busy;
  assign dbg_data    = r_regs[dbg_addr];

endmodule
